waveshape_sched: RTL and testbench



---
 rtl/synth_pkg.sv | 19 +
 rtl/sched_delay_line.sv | 37 +++
 rtl/waveshape_sched.sv | 147 ++++++++++++++
 tb/tb_waveshape_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared defaults and FSM encoding for the oscillator-voice scheduling blocks.
package synth_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_PHASE_W    = 11;

  function automatic int shape_default(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int SHAPE_DEFAULT = shape_default(DEF_PHASE_W);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

endpackage

// File: rtl/sched_delay_line.sv
// DEPTH-stage shift register tracking {valid, idx} of in-flight shaper issues; output appears DEPTH clocks after input.
// No backpressure: shifts every cycle; any_vld reports whether any issue is still in flight.
module sched_delay_line #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             any_vld
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/waveshape_sched.sv
// Time-multiplexes one waveshaper over NUM_VOICES voices; all voices commit NUM_VOICES+SHAPER_LAT+2 clocks after an accepted tick.
// No backpressure: the shaper takes one issue per cycle; ticks arriving while busy are dropped and flagged in overrun.
module waveshape_sched
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int SHAPER_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES*PHASE_W-1:0] phase_in,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_shape,
  input  logic                          ovr_clr,
  output logic                          sh_valid,
  output logic [PHASE_W-1:0]            sh_phase,
  output logic [PHASE_W-1:0]            sh_shape,
  input  logic [PHASE_W-1:0]            sh_result,
  output logic [NUM_VOICES*PHASE_W-1:0] voice_out,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          overrun
);

  localparam int                 IDX_W      = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_VOICES - 1);
  localparam logic [PHASE_W-1:0] SHAPE_INIT = PHASE_W'(shape_default(PHASE_W));

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PHASE_W-1:0] snap_q    [NUM_VOICES];
  logic [PHASE_W-1:0] active_q  [NUM_VOICES];
  logic [PHASE_W-1:0] shadow_q  [NUM_VOICES];
  logic [PHASE_W-1:0] staging_q [NUM_VOICES];

  logic             tick_accept;
  logic             issue_vld;
  logic             res_vld;
  logic [IDX_W-1:0] res_idx;
  logic             dl_busy;

  assign tick_accept = sample_tick && (state_q == ST_IDLE);
  assign issue_vld   = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign sh_valid    = issue_vld;
  assign sh_phase    = issue_vld ? snap_q[idx_q]   : '0;
  assign sh_shape    = issue_vld ? active_q[idx_q] : '0;

  sched_delay_line #(
    .DEPTH (SHAPER_LAT),
    .IDX_W (IDX_W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (issue_vld),
    .in_idx  (idx_q),
    .out_vld (res_vld),
    .out_idx (res_idx),
    .any_vld (dl_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_accept) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
          end
        end
        ST_ISSUE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DRAIN;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        // Leave only once the final result has landed in staging.
        ST_DRAIN:  if (!dl_busy) state_q <= ST_COMMIT;
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Active shapes follow the shadow copy only at frame start, so a write in the
  // accepting cycle lands in shadow and is seen one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        snap_q[v]   <= '0;
        active_q[v] <= SHAPE_INIT;
      end
    end else if (tick_accept) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        snap_q[v]   <= phase_in[v*PHASE_W +: PHASE_W];
        active_q[v] <= shadow_q[v];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) shadow_q[v] <= SHAPE_INIT;
    end else if (cfg_we && (int'(cfg_voice) < NUM_VOICES)) begin
      shadow_q[cfg_voice] <= cfg_shape;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) staging_q[v] <= '0;
    end else if (res_vld) begin
      staging_q[res_idx] <= sh_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voice_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state_q == ST_COMMIT);
      if (state_q == ST_COMMIT) begin
        for (int v = 0; v < NUM_VOICES; v++) voice_out[v*PHASE_W +: PHASE_W] <= staging_q[v];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (sample_tick && busy) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_waveshape_sched.sv
// Bench for waveshape_sched: default instance (4 voices, latency 1) plus an 8-voice, latency-3 instance,
// each driven by a bench triangle shaper and checked every cycle against a frame-level model.
module tb_waveshape_sched;

  localparam int PW    = 11;
  localparam int NV_A  = 4;
  localparam int LAT_A = 1;
  localparam int NV_B  = 8;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          tick      [2];
  logic          cfg_we    [2];
  logic          ovr_clr   [2];
  logic [2:0]    cfg_voice [2];
  logic [PW-1:0] cfg_shape [2];
  logic [PW-1:0] ph        [2][8];

  logic [NV_A*PW-1:0] phase_a, vout_a;
  logic [NV_B*PW-1:0] phase_b, vout_b;
  logic               shv_a, shv_b, fd_a, fd_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [PW-1:0]      shp_a, shs_a, res_a, shp_b, shs_b, res_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fdc_a = 0;

  always_comb begin
    phase_a = '0;
    phase_b = '0;
    for (int v = 0; v < NV_A; v++) phase_a[v*PW +: PW] = ph[0][v];
    for (int v = 0; v < NV_B; v++) phase_b[v*PW +: PW] = ph[1][v];
  end

  waveshape_sched #(.NUM_VOICES(NV_A), .PHASE_W(PW), .SHAPER_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .sample_tick(tick[0]), .phase_in(phase_a),
    .cfg_we(cfg_we[0]), .cfg_voice(cfg_voice[0][1:0]), .cfg_shape(cfg_shape[0]), .ovr_clr(ovr_clr[0]),
    .sh_valid(shv_a), .sh_phase(shp_a), .sh_shape(shs_a), .sh_result(res_a),
    .voice_out(vout_a), .frame_done(fd_a), .busy(busy_a), .overrun(ovr_a)
  );

  waveshape_sched #(.NUM_VOICES(NV_B), .PHASE_W(PW), .SHAPER_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .sample_tick(tick[1]), .phase_in(phase_b),
    .cfg_we(cfg_we[1]), .cfg_voice(cfg_voice[1]), .cfg_shape(cfg_shape[1]), .ovr_clr(ovr_clr[1]),
    .sh_valid(shv_b), .sh_phase(shp_b), .sh_shape(shs_b), .sh_result(res_b),
    .voice_out(vout_b), .frame_done(fd_b), .busy(busy_b), .overrun(ovr_b)
  );

  // Triangle shaper: rises as 2*phase below the breakpoint, falls as its complement above.
  function automatic logic [PW-1:0] shape_fn(input logic [PW-1:0] p, input logic [PW-1:0] s);
    logic [PW-1:0] x;
    x = {p[PW-2:0], 1'b0};
    return (p < s) ? x : ~x;
  endfunction

  function automatic int nv(input int d);
    return (d == 0) ? NV_A : NV_B;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  // Registered external shapers; deliberately not reset so stale results keep arriving.
  logic [PW-1:0] pipe_a [LAT_A];
  logic [PW-1:0] pipe_b [LAT_B];
  always @(posedge clk) begin
    pipe_a[0] <= shape_fn(shp_a, shs_a);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= shape_fn(shp_b, shs_b);
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign res_a = pipe_a[LAT_A-1];
  assign res_b = pipe_b[LAT_B-1];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fd_a) fdc_a <= fdc_a + 1;

  task automatic chk(input string nm, input int d, input logic [87:0] got, input logic [87:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%0d want=%0d", nm, d, got, want);
    end
  endtask

  // Frame-level model: m_cnt counts edges since the accepting edge (-1 when idle).
  int            m_cnt    [2];
  logic [PW-1:0] m_shadow [2][8];
  logic [PW-1:0] m_act    [2][8];
  logic [PW-1:0] m_snap   [2][8];
  logic [PW-1:0] m_vout   [2][8];
  logic          m_fd     [2];
  logic          m_ovr    [2];
  bit            m_was_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = -1;
        m_fd[d]  = 1'b0;
        m_ovr[d] = 1'b0;
        for (int v = 0; v < 8; v++) begin
          m_shadow[d][v] = 11'd1024;
          m_act[d][v]    = 11'd1024;
          m_snap[d][v]   = '0;
          m_vout[d][v]   = '0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_was_busy = (m_cnt[d] >= 0);
        m_fd[d] = 1'b0;
        if (m_was_busy) begin
          m_cnt[d]++;
          if (m_cnt[d] == nv(d) + lat(d) + 2) begin
            for (int v = 0; v < nv(d); v++) m_vout[d][v] = shape_fn(m_snap[d][v], m_act[d][v]);
            m_fd[d]  = 1'b1;
            m_cnt[d] = -1;
          end
        end
        if (tick[d] && m_was_busy) m_ovr[d] = 1'b1;
        else if (ovr_clr[d])       m_ovr[d] = 1'b0;
        if (tick[d] && !m_was_busy) begin
          m_cnt[d] = 0;
          for (int v = 0; v < nv(d); v++) begin
            m_snap[d][v] = ph[d][v];
            m_act[d][v]  = m_shadow[d][v];
          end
        end
        if (cfg_we[d] && int'(cfg_voice[d]) < nv(d)) m_shadow[d][cfg_voice[d]] = cfg_shape[d];
      end
    end
  end

  logic [87:0]   c_ev, c_av;
  logic [PW-1:0] c_eph, c_esh;
  logic          c_iss;
  int            c_ci;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      c_iss = (m_cnt[d] >= 0) && (m_cnt[d] < nv(d));
      c_ci  = c_iss ? m_cnt[d] : 0;
      c_eph = c_iss ? m_snap[d][c_ci] : '0;
      c_esh = c_iss ? m_act[d][c_ci]  : '0;
      c_ev  = '0;
      for (int v = 0; v < nv(d); v++) c_ev[v*PW +: PW] = m_vout[d][v];
      c_av  = (d == 0) ? 88'(vout_a) : vout_b;
      chk("cyc_frame_done", d, 88'((d == 0) ? fd_a   : fd_b),   88'(m_fd[d]));
      chk("cyc_busy",       d, 88'((d == 0) ? busy_a : busy_b), 88'(m_cnt[d] >= 0));
      chk("cyc_overrun",    d, 88'((d == 0) ? ovr_a  : ovr_b),  88'(m_ovr[d]));
      chk("cyc_sh_valid",   d, 88'((d == 0) ? shv_a  : shv_b),  88'(c_iss));
      chk("cyc_sh_phase",   d, 88'((d == 0) ? shp_a  : shp_b),  88'(c_eph));
      chk("cyc_sh_shape",   d, 88'((d == 0) ? shs_a  : shs_b),  88'(c_esh));
      chk("cyc_voice_out",  d, c_av, c_ev);
    end
  end

  task automatic pulse_tick(input int d);
    @(posedge clk); #1;
    tick[d] = 1'b1;
    @(posedge clk); #1;
    tick[d] = 1'b0;
  endtask

  // Waits for frame_done; expected edge count is measured from the edge just before the call.
  task automatic wait_fd(input int d, input int exp_edges, input string nm);
    int  start;
    bit  seen;
    start = cyc;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((d == 0) ? fd_a : fd_b) seen = 1'b1;
    end
    chk(nm, d, seen ? 88'(cyc - start) : 88'(999), 88'(exp_edges));
  endtask

  task automatic set_basic_phases();
    ph[0][0] = 11'd100; ph[0][1] = 11'd600; ph[0][2] = 11'd1500; ph[0][3] = 11'd2047;
  endtask

  int fd_base;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tick[d] = 1'b0; cfg_we[d] = 1'b0; ovr_clr[d] = 1'b0;
      cfg_voice[d] = '0; cfg_shape[d] = '0;
      for (int v = 0; v < 8; v++) ph[d][v] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 0, 88'(busy_a), 88'(0));
    chk("rst_voice_out", 0, 88'(vout_a), 88'(0));
    chk("rst_sh_valid", 1, 88'(shv_b), 88'(0));
    rst = 1'b0;

    // Latency sweep on the 8-voice, latency-3 instance.
    for (int v = 0; v < NV_B; v++) ph[1][v] = 11'(v * 250 + 10);
    pulse_tick(1);
    wait_fd(1, 13, "lat_sweep_edges");
    chk("sweep_v0", 1, 88'(vout_b[10:0]),  88'(20));
    chk("sweep_v4", 1, 88'(vout_b[54:44]), 88'(2020));
    chk("sweep_v5", 1, 88'(vout_b[65:55]), 88'(1575));
    chk("sweep_v7", 1, 88'(vout_b[87:77]), 88'(575));

    // Basic frame.
    set_basic_phases();
    pulse_tick(0);
    wait_fd(0, 7, "basic_edges");
    chk("basic_v0", 0, 88'(vout_a[10:0]),  88'(200));
    chk("basic_v1", 0, 88'(vout_a[21:11]), 88'(1200));
    chk("basic_v2", 0, 88'(vout_a[32:22]), 88'(1095));
    chk("basic_v3", 0, 88'(vout_a[43:33]), 88'(1));

    // Atomic commit with phase_in changed mid-frame.
    ph[0][0] = 11'd0; ph[0][1] = 11'd1023; ph[0][2] = 11'd1024; ph[0][3] = 11'd2000;
    pulse_tick(0);
    repeat (2) begin @(posedge clk); #1; end
    for (int v = 0; v < NV_A; v++) ph[0][v] = 11'd555;
    chk("atomic_hold_v1", 0, 88'(vout_a[21:11]), 88'(1200));
    wait_fd(0, 5, "atomic_edges");
    chk("atomic_v1", 0, 88'(vout_a[21:11]), 88'(2046));
    chk("atomic_v2", 0, 88'(vout_a[32:22]), 88'(2047));
    chk("atomic_v3", 0, 88'(vout_a[43:33]), 88'(95));

    // Config write while busy: current frame keeps 1024, next uses 1600.
    set_basic_phases();
    pulse_tick(0);
    @(posedge clk); #1;
    cfg_we[0] = 1'b1; cfg_voice[0] = 3'd2; cfg_shape[0] = 11'd1600;
    @(posedge clk); #1;
    cfg_we[0] = 1'b0;
    wait_fd(0, 5, "cfg_busy_edges");
    chk("cfg_busy_v2", 0, 88'(vout_a[32:22]), 88'(1095));
    pulse_tick(0);
    wait_fd(0, 7, "cfg_next_edges");
    chk("cfg_next_v2", 0, 88'(vout_a[32:22]), 88'(952));

    // Config write coinciding with the accepted tick.
    @(posedge clk); #1;
    cfg_we[0] = 1'b1; cfg_voice[0] = 3'd2; cfg_shape[0] = 11'd500; tick[0] = 1'b1;
    @(posedge clk); #1;
    cfg_we[0] = 1'b0; tick[0] = 1'b0;
    wait_fd(0, 7, "cfg_tick_edges");
    chk("cfg_tick_same_v2", 0, 88'(vout_a[32:22]), 88'(952));
    pulse_tick(0);
    wait_fd(0, 7, "cfg_tick_next_edges");
    chk("cfg_tick_next_v2", 0, 88'(vout_a[32:22]), 88'(1095));

    // Overrun: second tick three cycles into a frame.
    pulse_tick(0);
    fd_base = fdc_a;
    repeat (2) begin @(posedge clk); #1; end
    tick[0] = 1'b1;
    @(posedge clk); #1;
    tick[0] = 1'b0;
    chk("ovr_set", 0, 88'(ovr_a), 88'(1));
    wait_fd(0, 4, "ovr_edges");
    repeat (12) @(posedge clk);
    #1;
    chk("ovr_one_frame", 0, 88'(fdc_a - fd_base), 88'(1));
    ovr_clr[0] = 1'b1;
    @(posedge clk); #1;
    ovr_clr[0] = 1'b0;
    chk("ovr_cleared", 0, 88'(ovr_a), 88'(0));

    // Tick during the frame_done cycle is accepted.
    pulse_tick(0);
    wait_fd(0, 7, "fdcyc_first_edges");
    tick[0] = 1'b1;
    @(posedge clk); #1;
    tick[0] = 1'b0;
    chk("fdcyc_busy", 0, 88'(busy_a), 88'(1));
    chk("fdcyc_no_ovr", 0, 88'(ovr_a), 88'(0));
    wait_fd(0, 7, "fdcyc_second_edges");

    // ovr_clr together with a dropped tick: set wins.
    pulse_tick(0);
    @(posedge clk); #1;
    tick[0] = 1'b1; ovr_clr[0] = 1'b1;
    @(posedge clk); #1;
    tick[0] = 1'b0; ovr_clr[0] = 1'b0;
    chk("ovr_set_wins", 0, 88'(ovr_a), 88'(1));
    wait_fd(0, 5, "ovr_clr_edges");

    // Reset in the middle of ISSUE.
    set_basic_phases();
    pulse_tick(0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_sh_valid", 0, 88'(shv_a), 88'(0));
    chk("mid_rst_busy", 0, 88'(busy_a), 88'(0));
    chk("mid_rst_voice_out", 0, 88'(vout_a), 88'(0));
    chk("mid_rst_overrun", 0, 88'(ovr_a), 88'(0));
    fd_base = fdc_a;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_no_frame", 0, 88'(fdc_a - fd_base), 88'(0));
    pulse_tick(0);
    wait_fd(0, 7, "post_rst_edges");
    chk("post_rst_v1", 0, 88'(vout_a[21:11]), 88'(1200));
    chk("post_rst_v2", 0, 88'(vout_a[32:22]), 88'(1095));

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

endmodule
